// File: rtl/unsigned_16b_isqrt_if.sv
// Handshake bundle for the sequential integer square root.
// slave  : the square-root block itself (accepts radicands, produces results).
// master : whoever feeds radicands and consumes results.
interface unsigned_16b_isqrt_if #(
    parameter int NBITS_IN = 16
);
    localparam int R = NBITS_IN / 2;

    logic                s_valid_i;
    logic                s_ready_o;
    logic [NBITS_IN-1:0] s_data_i;
    logic                m_valid_o;
    logic                m_ready_i;
    logic [R-1:0]        m_root_o;
    logic [R:0]          m_rem_o;

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_root_o, m_rem_o
    );

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_root_o, m_rem_o
    );
endinterface

// File: rtl/unsigned_16b_isqrt.sv
// Sequential unsigned integer square root, restoring digit-by-digit.
// One root bit is resolved per clock; a radicand of NBITS_IN bits yields an
// R = NBITS_IN/2 bit root and an R+1 bit remainder (x - root^2).
// NBITS_IN must be even and in 4..32; the interface instance must carry the
// same NBITS_IN value.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a radicand, s_ready_o high (after first clock)
// CALC  | one root bit resolved per cycle, R cycles total
// DONE  | result presented on m_*, held until m_ready_i is sampled high
module unsigned_16b_isqrt #(
    parameter int NBITS_IN = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    unsigned_16b_isqrt_if.slave  bus
);
    localparam int R  = NBITS_IN / 2;
    localparam int CW = $clog2(R);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [NBITS_IN-1:0] r_x;
    logic [R-1:0]        r_q;
    logic [R:0]          r_rm;
    logic [CW-1:0]       r_cnt;
    logic                r_s_ready;
    logic                r_m_valid;

    logic [R+1:0]        w_rm_sh;
    logic [R+1:0]        w_t;
    logic                w_ge;
    logic [R:0]          w_rm_nxt;
    logic [R-1:0]        w_q_nxt;

    // The partial remainder is bounded by 2*Q, and Q has at most R-1 bits
    // before the final step, so dropping r_rm[R] from the shift loses nothing.
    assign w_rm_sh = {r_rm[R-1:0], r_x[NBITS_IN-1 -: 2]};
    assign w_t     = {r_q, 2'b01};
    assign w_ge    = (w_rm_sh >= w_t);
    // When the trial subtraction succeeds the difference is <= 2*Q_new, which
    // always fits in R+1 bits, so the subtraction can be done at that width.
    // When it fails, w_rm_sh < 4Q+1, which also fits in R+1 bits.
    assign w_rm_nxt = w_ge ? (w_rm_sh[R:0] - w_t[R:0]) : w_rm_sh[R:0];
    assign w_q_nxt  = {r_q[R-2:0], w_ge};

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_q       <= '0;
            r_rm      <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (bus.s_valid_i && r_s_ready) begin
                        r_x       <= bus.s_data_i;
                        r_q       <= '0;
                        r_rm      <= '0;
                        r_cnt     <= CW'(R - 1);
                        r_s_ready <= 1'b0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_x  <= {r_x[NBITS_IN-3:0], 2'b00};
                    r_q  <= w_q_nxt;
                    r_rm <= w_rm_nxt;
                    if (r_cnt == '0) begin
                        r_m_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.m_ready_i) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o = r_s_ready;
    assign bus.m_valid_o = r_m_valid;
    assign bus.m_root_o  = r_q;
    assign bus.m_rem_o   = r_rm;
endmodule

// File: doc/unsigned_16b_isqrt.md
# unsigned_16b_isqrt

Sequential unsigned integer square root: the inverse of the signed 8-bit squarer. It accepts an NBITS_IN-bit unsigned radicand (16-bit by default) and returns floor(sqrt(x)) plus the remainder x − root². It uses a restoring digit-by-digit algorithm that resolves one root bit per clock. It sits downstream of power/energy accumulation paths, converting squared magnitudes back to linear amplitude, with valid/ready handshakes on both sides.

## Interface
- NBITS_IN, default 16: radicand width; must be even, 4..32. Root width R = NBITS_IN/2; remainder width R+1.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- s_valid_i  in  1  radicand valid.
- s_ready_o  out  1  block can accept a radicand.
- s_data_i  in  NBITS_IN  unsigned radicand x.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  downstream accepts result.
- m_root_o  out  R  floor(sqrt(x)).
- m_rem_o  out  R+1  x − root², range 0..2·root.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - s_ready_o=1.
  - On s_valid_i && s_ready_o, capture s_data_i into shift register X, clear Q (root) and Rm (remainder), load iteration counter with R−1, go to CALC.
- CALC, once per cycle:
  - Rm' = (Rm<<2) | X[top 2 bits]; X <<= 2.
  - T = (Q<<2) | 1.
  - If Rm' ≥ T: Rm = Rm' − T, Q = (Q<<1)|1. Otherwise Rm = Rm', Q = Q<<1.
  - Counter decrements. The iteration executed with counter==0 is the last; go to DONE.
- Width rules:
  - Rm' and T are computed at R+2 bits.
  - The final Rm fits in R+1 bits. No saturation or truncation occurs anywhere.
- DONE:
  - m_valid_o=1; m_root_o=Q; m_rem_o=Rm.
  - Outputs are held stable until m_ready_i is sampled high, then go to IDLE.
- s_valid_i and s_data_i are ignored outside IDLE; s_ready_o=0 in CALC and DONE.
- m_root_o and m_rem_o are driven from the Q and Rm registers. Their value outside DONE is don't-care for consumers but must not be X after reset.

## Timing
- Reset values:
  - State IDLE; Q, Rm, X and counter all 0.
  - m_valid_o=0; m_root_o=0; m_rem_o=0.
  - s_ready_o=0 while rst_ni is low. s_ready_o is registered and rises at the first rising clk_i edge after rst_ni deasserts.
- Latency:
  - Input handshake at edge E0; CALC iterations occur on edges E1..ER.
  - m_valid_o rises after edge ER. This is R cycles, 8 for the default.
- Throughput:
  - Output handshake at edge Ek returns the block to IDLE, with s_ready_o=1 in the following cycle.
  - Minimum spacing between accepted inputs is R+2 cycles (10 for the default).
- m_ready_i may be held high in advance. The result then completes on the first DONE cycle.
- m_ready_i high outside DONE has no effect.
- Reset mid-operation:
  - Asserting rst_ni in CALC or DONE aborts immediately, with m_valid_o=0 asynchronously.
  - The in-flight result is discarded and is never presented after reset.
- No combinational path from any input to any output.

## Test plan
- x=0 → root 0, rem 0; x=1 → root 1, rem 0; x=2 → root 1, rem 1. Each m_valid_o rises exactly 8 cycles after its input handshake.
- Boundaries:
  - x=65535 → root 255, rem 510.
  - x=16384 → root 128, rem 0.
  - x=16383 → root 127, rem 254.
- Backpressure: hold m_ready_i=0 for 5 cycles in DONE. m_valid_o, root and rem stay constant, and s_ready_o stays 0. Release → next-cycle s_ready_o=1.
- Protocol: s_valid_i held high with changing s_data_i during CALC. Only the value captured at E0 affects the result; back-to-back inputs are spaced exactly 10 cycles with m_ready_i tied high.
- Reset: assert rst_ni low at iteration 4 of x=40000, then release. m_valid_o=0 immediately and the outputs read 0. The next input x=40000 → root 200, rem 0.
- Exhaustive sweep of x=0..65535 with random m_ready_i stalls. Every result satisfies root² + rem = x and 0 ≤ rem ≤ 2·root. Repeat with NBITS_IN=8 (root 4 bits) over x=0..255.
